// File: rtl/trng_req_arbiter.sv
// Round-robin arbiter and read sequencer sharing the TRNG word FIFO among N_REQ cores.
// Each grant reads WORDS back-to-back words and delivers one BLOCK_SIZE-bit block via valid/ready.
module trng_req_arbiter #(
  parameter int BLOCK_SIZE = 128,
  parameter int Dbw        = 32,
  parameter int N_REQ      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req,
  output logic [N_REQ-1:0]      gnt,
  output logic [BLOCK_SIZE-1:0] blk_out,
  output logic                  blk_valid,
  input  logic [N_REQ-1:0]      blk_ready,
  output logic                  mem_read,
  output logic                  mem_ren,
  input  logic [Dbw-1:0]        mem_out,
  input  logic                  mem_valid,
  output logic                  busy
);

  localparam int WORDS = BLOCK_SIZE / Dbw;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, READ, LAST, DONE} state_t;

  state_t             state, state_d;
  logic [N_REQ-1:0]   gnt_d;
  logic [IDX_W-1:0]   gnt_idx, gnt_idx_d;
  logic [IDX_W-1:0]   last_gnt, last_gnt_d;
  logic [CNT_W-1:0]   rd_cnt, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt;
  logic               rd_d;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;

  // Descending scan: the last hit wins, i.e. the first set bit upward from last_gnt+1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_gnt) + i) % N_REQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    gnt_idx_d  = gnt_idx;
    last_gnt_d = last_gnt;
    rd_cnt_d   = rd_cnt;
    unique case (state)
      IDLE: if (pick_valid) begin
        gnt_d           = '0;
        gnt_d[pick_idx] = 1'b1;
        gnt_idx_d       = pick_idx;
        state_d         = WAIT;
      end
      WAIT: begin
        if (!req[gnt_idx]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (mem_valid) begin
          rd_cnt_d = '0;
          state_d  = READ;
        end
      end
      READ: begin
        rd_cnt_d = rd_cnt + CNT_W'(1);
        if (rd_cnt == CNT_W'(WORDS - 1)) state_d = LAST;
      end
      LAST: state_d = DONE;
      DONE: if (blk_ready[gnt_idx]) begin
        last_gnt_d = gnt_idx;
        gnt_d      = '0;
        state_d    = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      last_gnt <= IDX_W'(N_REQ - 1);
      rd_cnt   <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      gnt_idx  <= gnt_idx_d;
      last_gnt <= last_gnt_d;
      rd_cnt   <= rd_cnt_d;
    end
  end

  // FIFO data is registered, so word k lands one cycle after its strobe (tracked by rd_d).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the block register is reset because blk_out must read zero out of reset, unlike a plain data buffer.
      blk_out <= '0;
      rd_d    <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      rd_d <= mem_read;
      if (state == WAIT) begin
        wr_cnt <= '0;
      end else if (rd_d) begin
        blk_out[int'(wr_cnt) * Dbw +: Dbw] <= mem_out;
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
    end
  end

  assign mem_read  = (state == READ);
  assign mem_ren   = mem_read;
  assign blk_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_trng_req_arbiter.sv
// Directed bench for trng_req_arbiter (N_REQ=2, Dbw=32, WORDS=4) with a simple FIFO responder.
// FIFO word p holds 0x11*(p+1); the read pointer is never rewound, even across reset.
module tb_trng_req_arbiter;

  logic         clk;
  logic         reset_n;
  logic [1:0]   req;
  logic [1:0]   gnt;
  logic [127:0] blk_out;
  logic         blk_valid;
  logic [1:0]   blk_ready;
  logic         mem_read;
  logic         mem_ren;
  logic [31:0]  mem_out;
  logic         mem_valid;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int mem_ptr = 0;
  int p0;
  logic [127:0] hold_blk;
  logic [1:0]   rr_exp [4];

  trng_req_arbiter #(.BLOCK_SIZE(128), .Dbw(32), .N_REQ(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .blk_out   (blk_out),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .mem_read  (mem_read),
    .mem_ren   (mem_ren),
    .mem_out   (mem_out),
    .mem_valid (mem_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int p);
    return 32'(32'h11 * (p + 1));
  endfunction

  function automatic logic [127:0] exp_blk(input int b);
    return {word(b + 3), word(b + 2), word(b + 1), word(b)};
  endfunction

  // FIFO model: registered read data, pointer advances per strobe.
  always @(posedge clk) begin
    if (mem_read) begin
      mem_out <= word(mem_ptr);
      mem_ptr <= mem_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (blk_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(tag, 128'(blk_valid), 128'(1'b1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"},       128'(gnt),       128'(0));
    check({tag, " blk_valid"}, 128'(blk_valid), 128'(0));
    check({tag, " blk_out"},   blk_out,         128'(0));
    check({tag, " mem_read"},  128'(mem_read),  128'(0));
    check({tag, " mem_ren"},   128'(mem_ren),   128'(0));
    check({tag, " busy"},      128'(busy),      128'(0));
  endtask

  initial begin
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    reset_n = 1'b0; req = '0; blk_ready = '0; mem_valid = 1'b0;
    #1;
    check_all_zero("reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single request, best-case latency.
    mem_valid = 1'b1; req = 2'b01;
    tick();
    check("single gnt c1", 128'(gnt), 128'(2'b01));
    check("single busy c1", 128'(busy), 128'(1));
    check("single no read c1", 128'(mem_read), 128'(0));
    for (int c = 2; c <= 5; c++) begin
      tick();
      check("single mem_read c2-5", 128'(mem_read), 128'(1));
      check("single mem_ren c2-5", 128'(mem_ren), 128'(1));
    end
    tick();
    check("single LAST no read", 128'(mem_read), 128'(0));
    check("single LAST no valid", 128'(blk_valid), 128'(0));
    tick();
    check("single valid c7", 128'(blk_valid), 128'(1));
    check("single blk_out", blk_out, 128'h00000044_00000033_00000022_00000011);
    check("single read count", 128'(mem_ptr), 128'(4));
    blk_ready = 2'b01; req = '0;
    tick();
    check("single idle valid", 128'(blk_valid), 128'(0));
    check("single idle gnt", 128'(gnt), 128'(0));
    check("single idle busy", 128'(busy), 128'(0));
    blk_ready = '0;

    // Round robin from a fresh reset: requester 0 first.
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    req = 2'b11; blk_ready = 2'b11;
    for (int b = 0; b < 4; b++) begin
      p0 = mem_ptr;
      wait_valid("rr valid");
      check("rr gnt order", 128'(gnt), 128'(rr_exp[b]));
      check("rr blk_out", blk_out, exp_blk(p0));
      check("rr read count", 128'(mem_ptr - p0), 128'(4));
      tick();
      check("rr idle after handshake", 128'(busy), 128'(0));
    end
    req = '0; blk_ready = '0;

    // FIFO starvation: stays in WAIT with no reads.
    mem_valid = 1'b0; req = 2'b01;
    tick();
    check("starve gnt", 128'(gnt), 128'(2'b01));
    p0 = mem_ptr;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("starve no read", 128'(mem_read), 128'(0));
      check("starve gnt held", 128'(gnt), 128'(2'b01));
    end
    check("starve read count", 128'(mem_ptr - p0), 128'(0));
    mem_valid = 1'b1;
    tick();
    check("starve read starts", 128'(mem_read), 128'(1));
    wait_valid("starve valid");
    check("starve blk_out", blk_out, exp_blk(p0));
    blk_ready = 2'b01; req = '0;
    tick();
    check("starve idle", 128'(busy), 128'(0));
    blk_ready = '0;

    // Withdrawal in WAIT: grant dropped, no reads, last_gnt unchanged (still 0).
    mem_valid = 1'b0; req = 2'b10; p0 = mem_ptr;
    tick();
    check("wd wait gnt", 128'(gnt), 128'(2'b10));
    tick();
    req = '0;
    tick();
    check("wd wait gnt cleared", 128'(gnt), 128'(0));
    check("wd wait idle", 128'(busy), 128'(0));
    mem_valid = 1'b1;
    tick();
    check("wd wait no reads", 128'(mem_ptr - p0), 128'(0));

    // Withdrawal in READ: block still delivered; requester 1 wins since last_gnt is 0.
    req = 2'b11;
    tick();
    check("wd read gnt", 128'(gnt), 128'(2'b10));
    tick();
    check("wd read strobe", 128'(mem_read), 128'(1));
    req = 2'b01;
    wait_valid("wd read valid");
    check("wd read gnt held", 128'(gnt), 128'(2'b10));
    check("wd read blk_out", blk_out, exp_blk(p0));
    blk_ready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("wd read ignore other ready", 128'(blk_valid), 128'(1));
    end
    blk_ready = 2'b10; req = '0;
    tick();
    check("wd read handshake valid", 128'(blk_valid), 128'(0));
    check("wd read handshake gnt", 128'(gnt), 128'(0));
    check("wd read read count", 128'(mem_ptr - p0), 128'(4));
    blk_ready = '0;

    // Backpressure: output frozen while ready is low.
    p0 = mem_ptr; req = 2'b01;
    wait_valid("bp valid");
    check("bp gnt", 128'(gnt), 128'(2'b01));
    hold_blk = exp_blk(p0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("bp valid held", 128'(blk_valid), 128'(1));
      check("bp blk_out stable", blk_out, hold_blk);
    end
    check("bp no extra reads", 128'(mem_ptr - p0), 128'(4));
    blk_ready = 2'b01; req = '0;
    tick();
    check("bp idle", 128'(busy), 128'(0));
    check("bp valid dropped", 128'(blk_valid), 128'(0));
    blk_ready = '0;

    // Async reset after the second read of a block.
    p0 = mem_ptr; req = 2'b01;
    tick(); tick(); tick(); tick();
    check("areset reads before", 128'(mem_ptr - p0), 128'(2));
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("areset");
    #2 reset_n = 1'b1;
    tick();
    check("areset regrant 0", 128'(gnt), 128'(2'b01));
    wait_valid("areset valid");
    check("areset fresh blk_out", blk_out, exp_blk(p0 + 2));
    check("areset full reads", 128'(mem_ptr - p0), 128'(6));
    blk_ready = 2'b01; req = '0;
    tick();
    check("areset idle", 128'(busy), 128'(0));
    blk_ready = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trng_req_arbiter.md
# trng_req_arbiter

Round-robin arbiter and read sequencer that shares the TRNG word FIFO among `N_REQ` consumer cores (e.g. KEM/signature engines). On a granted request it waits for the FIFO to report a full block available. It then issues exactly `BLOCK_SIZE/Dbw` back-to-back reads, assembles the returned words into one `BLOCK_SIZE`-bit block, and delivers it to the granted requester with a valid/ready handshake. It sits between the TRNG memory read port and the consumer cores.

## Interface
Parameters:
- `BLOCK_SIZE`, 128: random block width delivered per grant (bits); must be a multiple of `Dbw`.
- `Dbw`, 32: TRNG memory word width (bits); 32 or 64.
- `N_REQ`, 2: number of requesters; ≥1.
- Derived `WORDS` = `BLOCK_SIZE/Dbw`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester block request, level.
- `gnt`  out  N_REQ  one-hot grant; all-zero when idle.
- `blk_out`  out  BLOCK_SIZE  assembled random block.
- `blk_valid`  out  1  `blk_out` valid for the granted requester.
- `blk_ready`  in  N_REQ  per-requester accept.
- `mem_read`  out  1  FIFO read strobe.
- `mem_ren`  out  1  FIFO read enable; always equal to `mem_read`.
- `mem_out`  in  Dbw  FIFO read data; registered, valid the cycle after a read.
- `mem_valid`  in  1  FIFO holds more than `WORDS` words.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, READ, LAST, DONE.
- **IDLE**:
  - If any `req` bit is set, select the first set bit searching upward from `last_gnt+1`, modulo `N_REQ`.
  - Register the selection into `gnt` and go to WAIT.
  - If no `req` bit is set, stay in IDLE.
- **WAIT**:
  - If the granted `req` bit drops, clear `gnt` and return to IDLE. No reads are issued and `last_gnt` is unchanged.
  - Otherwise, if `mem_valid` is high, clear `rd_cnt` and go to READ.
- **READ**:
  - Drive `mem_read=mem_ren=1` every cycle and increment `rd_cnt`.
  - When `rd_cnt==WORDS-1`, go to LAST. Exactly `WORDS` strobes are issued.
- **LAST**: no strobe; capture the final word, then go to DONE.
- **DONE**:
  - Hold `blk_valid=1`.
  - When `blk_ready` for the granted index is high: set `last_gnt`←granted index, clear `gnt`, go to IDLE.
- **Capture**:
  - A 1-bit `rd_d` register follows `mem_read`, delayed one cycle.
  - When `rd_d=1`, word k (k-th read, 0-based) is written to `blk_out[k*Dbw +: Dbw]`.
- Once READ is entered, a drop of `req` is ignored; the transaction completes and waits in DONE.
- Ready bits of non-granted requesters are ignored.
- `mem_valid` is not re-checked during READ. The FIFO never underflows because it held more than `WORDS` words at READ entry and only this block reads it.

## Timing
- Reset values:
  - `gnt=0`, `blk_valid=0`, `blk_out=0`, `mem_read=mem_ren=0`, `busy=0`.
  - State IDLE, `last_gnt=N_REQ-1` (so requester 0 wins first), `rd_cnt=0`, `rd_d=0`.
- All outputs are registered or decoded from registered state only; there are no combinational paths from input to output.
- Best-case latency, with `req` sampled at edge 0 and `mem_valid` already high:
  - `gnt` high in cycle 1 (WAIT).
  - `mem_read` high in cycles 2..WORDS+1.
  - LAST in cycle WORDS+2.
  - `blk_valid` high from cycle WORDS+3.
  - For `WORDS=4`: reads in cycles 2–5 and `blk_valid` in cycle 7.
- Handshake: `blk_out` is stable while `blk_valid` is high, and `blk_valid` holds until ready.
  - Ready in the first DONE cycle gives `blk_valid` for exactly one cycle.
  - The next grant can be issued one cycle after handshake (IDLE cycle).
- Reset asserted mid-READ: everything clears immediately. The partial block is discarded and the FIFO read pointer is not restored; those words are consumed.
- Arbitration uses fair round-robin. A requester holding `req` continuously waits at most `N_REQ-1` other grants.

## Test plan
- Single request, `N_REQ=2`, `WORDS=4`, `mem_valid=1`, `req[0]=1` at cycle 0, `mem_out` returns 0x11,0x22,0x33,0x44:
  - `gnt=01` at cycle 1; reads in cycles 2–5.
  - `blk_valid` at cycle 7 with `blk_out=0x00000044_00000033_00000022_00000011`.
- Round robin: `req=11` held, `blk_ready=11` → grant order 0,1,0,1 across four blocks, each block exactly 4 `mem_read` pulses.
- FIFO starvation: `mem_valid=0` for 10 cycles after grant → stays in WAIT, zero reads; `mem_valid` rises → reads start next cycle.
- Withdrawal: `req[1]` drops in WAIT → `gnt=00` next cycle and no reads. `req[1]` dropping during READ → block still delivered, `blk_valid` held until `blk_ready[1]`.
- Backpressure: `blk_ready=0` for 20 cycles in DONE → `blk_valid` and `blk_out` constant, no extra reads; `blk_ready[0]` pulse → IDLE next cycle.
- Async reset: `reset_n` low for a partial cycle after the 2nd read → all outputs 0 immediately. After release, `req[0]` → fresh full 4-read transaction, requester 0 granted first.
